// File: rtl/vga_plot_arbiter_if.sv
// Write-port bundle between the drawing engines (master) and vga_plot_arbiter (slave).
// Per-requester lanes are packed: requester i owns x_in[8i+:8], y_in[7i+:7], colour_in[3i+:3].
interface vga_plot_arbiter_if #(
    parameter int N     = 4,
    parameter int CNT_W = 16
);
    logic [N-1:0]     req;
    logic [N-1:0]     plot_in;
    logic [8*N-1:0]   x_in;
    logic [7*N-1:0]   y_in;
    logic [3*N-1:0]   colour_in;
    logic [N-1:0]     gnt;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] pix_count;

    modport master (
        output req, plot_in, x_in, y_in, colour_in,
        input  gnt, vga_x, vga_y, vga_colour, vga_plot, busy, err, pix_count
    );

    modport slave (
        input  req, plot_in, x_in, y_in, colour_in,
        output gnt, vga_x, vga_y, vga_colour, vga_plot, busy, err, pix_count
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing the VGA adapter write port among N drawing engines.
// Define VGA_ARB_CLIP_EN to drop granted pixels outside the 160x120 screen.
module vga_plot_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    vga_plot_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] pick;
    logic             found;

    logic [7:0]       vga_x_q;
    logic [6:0]       vga_y_q;
    logic [2:0]       vga_colour_q;
    logic             vga_plot_q;
    logic             err_q;
    logic [CNT_W-1:0] pix_count_q;

    logic [7:0]       sel_x;
    logic [6:0]       sel_y;
    logic [2:0]       sel_colour;
    logic             sel_plot;
    logic             sel_req;
    logic             on_screen;
    logic             fwd;

    // ptr_q names the owner throughout GRANT, so it doubles as the lane select
    always_comb begin
        sel_x      = bus.x_in[8*int'(ptr_q) +: 8];
        sel_y      = bus.y_in[7*int'(ptr_q) +: 7];
        sel_colour = bus.colour_in[3*int'(ptr_q) +: 3];
        sel_plot   = bus.plot_in[ptr_q];
        sel_req    = bus.req[ptr_q];
    end

`ifdef VGA_ARB_CLIP_EN
    assign on_screen = (sel_x < 8'd160) && (sel_y < 7'd120);
`else
    assign on_screen = 1'b1;
`endif

    assign fwd = (state_q == GRANT) && sel_plot && on_screen;

    // First pending request strictly after the last owner, wrapping modulo N
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d     = GRANT;
                    ptr_d       = pick;
                    gnt_d[pick] = 1'b1;
                end
            end
            GRANT: begin
                if (!sel_req) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_W'(N - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            err_q        <= 1'b0;
            pix_count_q  <= '0;
        end else begin
            vga_plot_q <= fwd;
            if (fwd) begin
                vga_x_q      <= sel_x;
                vga_y_q      <= sel_y;
                vga_colour_q <= sel_colour;
            end
            if (|(bus.plot_in & ~gnt_q))
                err_q <= 1'b1;
            if (fwd && (pix_count_q != '1))
                pix_count_q <= pix_count_q + 1'b1;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.err        = err_q;
    assign bus.pix_count  = pix_count_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: owner/cooldown reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_vga_plot_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.N(N), .CNT_W(16)) bus ();
    vga_plot_arbiter_if #(.N(N), .CNT_W(4))  sbus ();

    assign sbus.req       = bus.req;
    assign sbus.plot_in   = bus.plot_in;
    assign sbus.x_in      = bus.x_in;
    assign sbus.y_in      = bus.y_in;
    assign sbus.colour_in = bus.colour_in;

    vga_plot_arbiter #(.N(N), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus));
    vga_plot_arbiter #(.N(N), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many dead cycles remain, who won last
    bit m_valid = 1'b0;
    int m_owner, m_dead, m_last, m_cnt;
    bit m_err, m_plot;
    int m_x, m_y, m_c;

    function automatic bit in_screen(input int x, input int y);
`ifdef VGA_ARB_CLIP_EN
        return (x < 160) && (y < 120);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        int px, py, pc;
        if (rst) begin
            m_valid = 1'b1; m_owner = -1; m_dead = 0; m_last = N - 1; m_cnt = 0;
            m_err = 1'b0; m_plot = 1'b0; m_x = 0; m_y = 0; m_c = 0;
            return;
        end
        if (!m_valid) return;
        for (int i = 0; i < N; i++)
            if (bus.plot_in[i] && i != m_owner) m_err = 1'b1;
        m_plot = 1'b0;
        if (m_owner >= 0) begin
            px = int'(bus.x_in[8*m_owner +: 8]);
            py = int'(bus.y_in[7*m_owner +: 7]);
            pc = int'(bus.colour_in[3*m_owner +: 3]);
            if (bus.plot_in[m_owner] && in_screen(px, py)) begin
                m_plot = 1'b1; m_x = px; m_y = py; m_c = pc; m_cnt++;
            end
            if (!bus.req[m_owner]) begin
                m_owner = -1;
                m_dead  = 1;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (bus.req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && bus.req[c]) m_owner = c;
            end
            m_last = m_owner;
        end
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        if (m_valid) begin
            check("gnt", bus.gnt, (m_owner < 0) ? 0 : (1 << m_owner));
            check("busy", bus.busy, (m_owner >= 0) || (m_dead > 0));
            check("vga_plot", bus.vga_plot, m_plot);
            check("vga_x", bus.vga_x, m_x);
            check("vga_y", bus.vga_y, m_y);
            check("vga_colour", bus.vga_colour, m_c);
            check("err", bus.err, m_err);
            check("pix_count", bus.pix_count, (m_cnt > 65535) ? 65535 : m_cnt);
            check("pix_count_sat", sbus.pix_count, (m_cnt > 15) ? 15 : m_cnt);
        end
    end

    // Requester agents: raise req, plot while granted, drop req with the last pixel
    bit [N-1:0] agent_on;
    int left [N];
    int burst_len;

    task automatic agent_step(input bit random_mode);
        logic [N-1:0] g;
        int v;
        g = bus.gnt;
        for (int i = 0; i < N; i++) begin
            if (!agent_on[i]) continue;
            bus.plot_in[i] = 1'b0;
            if (g[i] && left[i] > 0) begin
                if (!random_mode || $urandom_range(0, 3) != 0) begin
                    bus.plot_in[i]            = 1'b1;
                    bus.x_in[8*i +: 8]        = 8'($urandom_range(0, 255));
                    bus.y_in[7*i +: 7]        = 7'($urandom_range(0, 127));
                    bus.colour_in[3*i +: 3]   = 3'($urandom_range(0, 7));
                    left[i]--;
                    if (left[i] == 0) bus.req[i] = 1'b0;
                end
            end else if (!g[i] && !bus.req[i] && (!random_mode || $urandom_range(0, 2) == 0)) begin
                bus.req[i] = 1'b1;
                left[i]    = random_mode ? $urandom_range(1, 8) : burst_len;
            end
        end
        if (random_mode && $urandom_range(0, 49) == 0) begin
            v = $urandom_range(0, N - 1);
            if (!g[v]) bus.plot_in[v] = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        bus.req = '0; bus.plot_in = '0; agent_on = '0;
        for (int i = 0; i < N; i++) left[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic set_pix(input int i, input int x, input int y, input int c);
        bus.x_in[8*i +: 8]      = 8'(x);
        bus.y_in[7*i +: 7]      = 7'(y);
        bus.colour_in[3*i +: 3] = 3'(c);
    endtask

    initial begin
        int grants[$];
        int gaps[$];
        logic [N-1:0] prev;
        int gap;
        bit started, hit;

        bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
        clear_inputs();
        burst_len = 1;

        // Reset state
        do_reset();
        check("reset_gnt", bus.gnt, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_pix_count", bus.pix_count, 0);

        // Single burst from requester 0
        bus.req = 4'b0001;
        @(negedge clk);
        check("single_gnt", bus.gnt, 4'b0001);
        bus.plot_in[0] = 1'b1; set_pix(0, 10, 20, 2);
        @(negedge clk);
        check("single_px0", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, {1'b1, 8'd10, 7'd20, 3'd2});
        set_pix(0, 11, 20, 2);
        @(negedge clk);
        check("single_px1", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, {1'b1, 8'd11, 7'd20, 3'd2});
        set_pix(0, 12, 21, 2);
        @(negedge clk);
        check("single_px2", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, {1'b1, 8'd12, 7'd21, 3'd2});
        check("single_count", bus.pix_count, 3);
        bus.plot_in = '0; bus.req = '0;
        @(negedge clk);
        check("single_release_gnt", bus.gnt, 0);
        check("single_release_busy", bus.busy, 1);
        @(negedge clk);
        check("single_idle_busy", bus.busy, 0);

        // Contention: 0, 1, 3 each bursting 5 pixels and re-requesting at once
        do_reset();
        agent_on = 4'b1011; burst_len = 5;
        prev = '0; gap = 0; started = 1'b0;
        for (int c = 0; c < 300 && grants.size() < 5; c++) begin
            @(negedge clk);
            if (bus.gnt != '0 && prev == '0) begin
                grants.push_back(onehot_idx(bus.gnt));
                if (started) gaps.push_back(gap);
                started = 1'b1;
                gap = 0;
            end
            if (bus.gnt == '0) gap++;
            prev = bus.gnt;
            if (grants.size() < 5) agent_step(1'b0);
        end
        check("contention_grants_seen", grants.size(), 5);
        if (grants.size() >= 5) begin
            check("contention_order0", grants[0], 0);
            check("contention_order1", grants[1], 1);
            check("contention_order2", grants[2], 3);
            check("contention_order3", grants[3], 0);
            for (int k = 0; k < 4; k++) check("contention_gap", gaps[k], 2);
            check("contention_count", bus.pix_count, 20);
        end

        // Violation: requester 2 plots while requester 0 owns the port
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        bus.plot_in = 4'b0101; set_pix(0, 50, 60, 5); set_pix(2, 99, 9, 1);
        @(negedge clk);
        check("violation_err", bus.err, 1);
        check("violation_px", {bus.vga_plot, bus.vga_x, bus.vga_y}, {1'b1, 8'd50, 7'd60});
        bus.plot_in = 4'b0001; set_pix(0, 51, 61, 5);
        @(negedge clk);
        check("violation_px_next", bus.vga_x, 51);
        bus.plot_in = '0; bus.req = '0;
        repeat (4) @(negedge clk);
        check("violation_sticky", bus.err, 1);
        do_reset();
        check("violation_cleared", bus.err, 0);

        // Reset during requester 1's burst
        agent_on = 4'b0011; burst_len = 3; hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (bus.gnt == 4'b0010 && left[1] > 0 && left[1] < 3) hit = 1'b1;
            else agent_step(1'b0);
        end
        check("midburst_reached", hit, 1);
        agent_on = '0;
        bus.req = 4'b0011; bus.plot_in = 4'b0010; rst = 1'b1;
        @(negedge clk);
        check("midburst_gnt", bus.gnt, 0);
        check("midburst_plot", bus.vga_plot, 0);
        check("midburst_count", bus.pix_count, 0);
        check("midburst_err", bus.err, 0);
        rst = 1'b0; bus.plot_in = '0;
        @(negedge clk);
        check("midburst_regrant", bus.gnt, 4'b0001);

        // Screen-edge pixels
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        bus.plot_in[0] = 1'b1; set_pix(0, 159, 119, 3);
        @(negedge clk);
        set_pix(0, 160, 0, 4);
        @(negedge clk);
        bus.plot_in = '0;
`ifdef VGA_ARB_CLIP_EN
        check("clip_count", bus.pix_count, 1);
        check("clip_last", {bus.vga_plot, bus.vga_x}, {1'b0, 8'd159});
`else
        check("clip_count", bus.pix_count, 2);
        check("clip_last", {bus.vga_plot, bus.vga_x}, {1'b1, 8'd160});
`endif

        // 20-pixel burst against the 4-bit counter
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            bus.plot_in[0] = 1'b1; set_pix(0, i, i, i % 8);
            @(negedge clk);
        end
        bus.plot_in = '0;
        check("sat_count4", sbus.pix_count, 15);
        check("sat_count16", bus.pix_count, 20);

        // Randomized traffic with occasional violations and resets
        do_reset();
        agent_on = '1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                bus.req = '0; bus.plot_in = '0;
                for (int i = 0; i < N; i++) left[i] = 0;
            end else begin
                agent_step(1'b1);
            end
        end
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
